// File: rtl/core_launch_controller.sv
// rtl/core_launch_controller.sv - launches a masked set of cores, tracks per-core completion, watchdog and cycle count
module core_launch_controller #(
  parameter int          NUM_CORES = 3,
  parameter int unsigned TIMEOUT   = 32'hFFFF,
  parameter int          CNT_W     = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [NUM_CORES-1:0]   core_mask_i,
  input  logic [NUM_CORES-1:0]   end_process_i,
  output logic [2*NUM_CORES-1:0] status_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [NUM_CORES-1:0]   finished_o,
  output logic [CNT_W-1:0]       cycle_count_o
);

  localparam logic [1:0]       ST_HOLD   = 2'b00;
  localparam logic [1:0]       ST_RUN    = 2'b01;
  localparam logic [1:0]       ST_STOP   = 2'b10;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

  state_t                 state_q;
  logic [NUM_CORES-1:0]   mask_q;
  logic [NUM_CORES-1:0]   finished_q;
  logic [NUM_CORES-1:0]   finished_d;
  logic [CNT_W-1:0]       cycle_count_q;
  logic [CNT_W-1:0]       cycle_count_d;
  logic [2*NUM_CORES-1:0] status_q;
  logic                   done_q;
  logic                   timeout_q;
  logic                   all_done;
  logic [2*NUM_CORES-1:0] launch_status;
  logic [2*NUM_CORES-1:0] run_status;
  logic [2*NUM_CORES-1:0] stop_status;

  // finished_d includes completions arriving this cycle so the last one and DONE share an edge
  always_comb begin
    finished_d    = finished_q | (end_process_i & mask_q);
    all_done      = ((finished_d & mask_q) == mask_q);
    cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_W'(1);
    launch_status = '0;
    run_status    = '0;
    stop_status   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      launch_status[2*i +: 2] = core_mask_i[i] ? ST_RUN : ST_HOLD;
      run_status[2*i +: 2]    = !mask_q[i] ? ST_HOLD : (finished_d[i] ? ST_STOP : ST_RUN);
      stop_status[2*i +: 2]   = mask_q[i] ? ST_STOP : ST_HOLD;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      finished_q    <= '0;
      cycle_count_q <= '0;
      status_q      <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            finished_q    <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            if (core_mask_i == '0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              status_q <= '0;
            end else begin
              state_q  <= S_LAUNCH;
              mask_q   <= core_mask_i;
              status_q <= launch_status;
            end
          end
        end
        S_LAUNCH: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          finished_q    <= finished_d;
          cycle_count_q <= cycle_count_d;
          if (all_done) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            status_q <= stop_status;
          end else if (cycle_count_q == WDOG_LAST) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            status_q  <= stop_status;
          end else begin
            status_q <= run_status;
          end
        end
        S_DONE: begin
          // wait for start to drop so a held start cannot relaunch
          if (!start_i) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            status_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q == S_LAUNCH) || (state_q == S_RUN);
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign status_o      = status_q;
  assign finished_o    = finished_q;
  assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_core_launch_controller.sv
// tb/tb_core_launch_controller.sv - randomized job-level checks of core_launch_controller against a reference model
module tb_core_launch_controller;

  localparam int NC = 3;
  localparam int TO = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [NC-1:0] core_mask;
  logic [NC-1:0] end_process;
  logic [2*NC-1:0] status;
  logic          busy, done, timeout;
  logic [NC-1:0] finished;
  logic [15:0]   cycle_count;

  int total = 0;
  int bad   = 0;

  core_launch_controller #(.NUM_CORES(NC), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .core_mask_i(core_mask),
    .end_process_i(end_process), .status_o(status), .busy_o(busy), .done_o(done),
    .timeout_o(timeout), .finished_o(finished), .cycle_count_o(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Job-level model: core i completes at RUN cycle c[i] (1-based, 0 = never)
  task automatic run_job(input logic [NC-1:0] mask, input int c0, input int c1, input int c2,
                         input bit level);
    int c[NC];
    bit all_ok;
    int exp_cycles, runs, k;
    logic [NC-1:0] exp_fin;
    logic [2*NC-1:0] exp_st;
    bit seen_done;
    c[0] = c0; c[1] = c1; c[2] = c2;
    all_ok = 1; exp_cycles = 0; exp_fin = '0;
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        if (c[i] >= 1 && c[i] <= TO) begin
          exp_fin[i] = 1'b1;
          if (c[i] > exp_cycles) exp_cycles = c[i];
        end else all_ok = 0;
      end
    end
    if (!all_ok) exp_cycles = TO;

    @(negedge clock);
    start = 1'b1; core_mask = mask; end_process = '0;
    @(negedge clock);
    exp_st = '0;
    for (int i = 0; i < NC; i++) exp_st[2*i +: 2] = mask[i] ? 2'b01 : 2'b00;
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_status", 32'(status), 32'(exp_st));
    start = 1'b0;
    end_process = NC'($urandom);
    core_mask = NC'($urandom);

    runs = 0; seen_done = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (done) begin seen_done = 1; break; end
      runs++;
      exp_st = '0;
      for (int i = 0; i < NC; i++)
        if (mask[i]) exp_st[2*i +: 2] = (c[i] >= 1 && c[i] < k) ? 2'b10 : 2'b01;
      if (status !== exp_st) check("run_status", 32'(status), 32'(exp_st));
      for (int i = 0; i < NC; i++)
        end_process[i] = (c[i] != 0) && (level ? (k >= c[i]) : (k == c[i]));
      core_mask = NC'($urandom);
    end
    check("done_seen", 32'(seen_done), 32'd1);
    check("run_cycles", 32'(runs), 32'(exp_cycles));
    check("timeout", 32'(timeout), 32'(!all_ok));
    check("finished", 32'(finished), 32'(exp_fin));
    check("cycle_count", 32'(cycle_count), 32'(exp_cycles));
    exp_st = '0;
    for (int i = 0; i < NC; i++) exp_st[2*i +: 2] = mask[i] ? 2'b10 : 2'b00;
    check("done_status", 32'(status), 32'(exp_st));
    check("done_busy", 32'(busy), 32'd0);
    end_process = '0;
    @(negedge clock);
    check("idle_done", 32'(done), 32'd0);
    check("idle_status", 32'(status), 32'd0);
    check("idle_cnt_kept", 32'(cycle_count), 32'(exp_cycles));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; core_mask = '0; end_process = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_status", 32'(status), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_cnt", 32'(cycle_count), 32'd0);

    run_job(3'b111, 5, 12, 9, 0);
    run_job(3'b101, 4, 3, 7, 0);
    run_job(3'b011, 4, 0, 0, 0);
    run_job(3'b011, 3, 20, 0, 0);
    run_job(3'b010, 0, 21, 1, 1);

    @(negedge clock);
    start = 1'b1; core_mask = '0;
    @(negedge clock);
    check("empty_done", 32'(done), 32'd1);
    check("empty_cnt", 32'(cycle_count), 32'd0);
    check("empty_timeout", 32'(timeout), 32'd0);
    check("empty_status", 32'(status), 32'd0);
    repeat (3) @(negedge clock);
    check("empty_hold", 32'(done), 32'd1);
    start = 1'b0;
    @(negedge clock);
    check("empty_idle", 32'(done), 32'd0);
    start = 1'b1; core_mask = 3'b110;
    @(negedge clock);
    check("relaunch_busy", 32'(busy), 32'd1);
    start = 1'b0; end_process = 3'b010;
    repeat (4) @(negedge clock);
    check("midrun_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; end_process = '0;
    check("mrst_status", 32'(status), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_finished", 32'(finished), 32'd0);
    check("mrst_cnt", 32'(cycle_count), 32'd0);
    check("mrst_done", 32'(done), 32'd0);

    for (int j = 0; j < 30; j++)
      run_job(NC'($urandom_range(1, 7)), $urandom_range(0, 24), $urandom_range(0, 24),
              $urandom_range(0, 24), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
